// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer driving one shared instruction/data memory port.
// Latency: BRANCH 3, OP/OP-IMM/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5 cycles; +1 per memory wait cycle.
// Backpressure: FETCH and MEM hold mem_req/mem_we/mem_addr_sel steady until mem_ready; nothing else stalls.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   opcode              IR[6:0], meaningful from DECODE onward
//   br_taken            branch-compare result, used in EXEC
//   mem_ready           memory completes the pending access this cycle
//   mem_req/mem_we      memory request / store request
//   mem_addr_sel        0 = PC (instruction), 1 = ALU result (data)
//   ir_we               load IR from memory read data
//   pc_we/pc_sel        PC update; 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
//   reg_we/wb_sel       register write; 0 = ALU, 1 = load data, 2 = PC+4
//   state               current state encoding
//   illegal             sticky unknown-opcode flag
//   instret             retired-instruction counter (wraps silently)

module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_RSVD   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  state_t cur;

  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_jal;
  logic is_jalr;
  logic is_legal;

  assign state = cur;

  // The IR only changes on ir_we, so decoding the live opcode in every state
  // is equivalent to decoding a private copy taken in DECODE.
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_legal  = is_load | is_store | is_branch | is_jal | is_jalr |
                     (opcode == OPC_LUI)   | (opcode == OPC_AUIPC) |
                     (opcode == OPC_OPIMM) | (opcode == OPC_OP);

  // Strobes are decoded from the state register so that an asynchronous
  // reset drops every strobe in the same cycle it is asserted.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        // Branches retire here: no memory or writeback phase needed.
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PC_TARGET : PC_PLUS4;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        // Stores retire on the completing cycle; loads continue to WB.
        pc_we        = mem_ready & ~is_load;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (is_jal || is_jalr) begin
          wb_sel = WB_LINK;
        end else if (is_load) begin
          wb_sel = WB_LOAD;
        end
        if (is_jal) begin
          pc_sel = PC_TARGET;
        end else if (is_jalr) begin
          pc_sel = PC_JALR;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, sticky trap flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_IDLE;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      // Every instruction issues exactly one pc_we, so it doubles as retire.
      if (pc_we) begin
        instret <= instret + 32'd1;
      end
      case (cur)
        S_IDLE: begin
          cur <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            cur <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            cur <= S_EXEC;
          end else begin
            cur     <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            cur <= S_FETCH;
          end else if (is_load || is_store) begin
            cur <= S_MEM;
          end else begin
            cur <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            cur <= is_load ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          cur <= S_FETCH;
        end
        S_TRAP: begin
          // Only reset leaves the trap state.
          cur <= S_TRAP;
        end
        default: begin
          cur <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for the multi-cycle RV32I sequencer.
// Latency: each instruction is checked cycle by cycle against an expected trace.
// Backpressure: memory wait cycles are inserted in FETCH and MEM by the stimulus.

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .state        (state),
    .illegal      (illegal),
    .instret      (instret)
  );

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
  } vec_t;

  typedef struct packed {
    logic [6:0] op;
    logic       rdy;
    logic       bt;
  } stim_t;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_ir;
  vec_t        exp_q[$];
  vec_t        obs_q[$];
  stim_t       stim_q[$];
  logic [6:0]  legal_ops [9];

  function automatic vec_t sample();
    vec_t v;
    v.st           = state;
    v.mem_req      = mem_req;
    v.mem_we       = mem_we;
    v.mem_addr_sel = mem_addr_sel;
    v.ir_we        = ir_we;
    v.pc_we        = pc_we;
    v.pc_sel       = pc_sel;
    v.reg_we       = reg_we;
    v.wb_sel       = wb_sel;
    return v;
  endfunction

  function automatic void add(input vec_t v, input logic [6:0] op, input logic rdy, input logic bt);
    stim_t s;
    s.op  = op;
    s.rdy = rdy;
    s.bt  = bt;
    exp_q.push_back(v);
    stim_q.push_back(s);
  endfunction

  // Reference trace of one legal instruction: FETCH (with fw waits), DECODE,
  // EXEC, optional MEM (with mw waits), optional WB. mem_ready/br_taken are
  // randomised wherever they must be ignored.
  function automatic void build(input logic [6:0] op, input logic bt, input int fw, input int mw);
    vec_t v;
    logic ld;
    logic stq;
    logic br;
    ld  = (op == LOAD);
    stq = (op == STORE);
    br  = (op == BRANCH);
    exp_q.delete();
    stim_q.delete();
    for (int i = 0; i <= fw; i++) begin
      v = '0; v.st = 3'd1; v.mem_req = 1'b1; v.ir_we = (i == fw);
      add(v, 7'($urandom), (i == fw), 1'($urandom));
    end
    v = '0; v.st = 3'd2;
    add(v, op, 1'($urandom), 1'($urandom));
    v = '0; v.st = 3'd3;
    if (br) begin
      v.pc_we  = 1'b1;
      v.pc_sel = bt ? 2'd1 : 2'd0;
    end
    add(v, op, 1'($urandom), bt);
    if (ld || stq) begin
      for (int i = 0; i <= mw; i++) begin
        v = '0; v.st = 3'd4; v.mem_req = 1'b1; v.mem_addr_sel = 1'b1; v.mem_we = stq;
        v.pc_we = stq && (i == mw);
        add(v, op, (i == mw), 1'($urandom));
      end
    end
    if (!br && !stq) begin
      v = '0; v.st = 3'd5; v.reg_we = 1'b1; v.pc_we = 1'b1;
      v.wb_sel = (op == JAL || op == JALR) ? 2'd2 : (ld ? 2'd1 : 2'd0);
      v.pc_sel = (op == JAL) ? 2'd1 : ((op == JALR) ? 2'd2 : 2'd0);
      add(v, op, 1'($urandom), 1'($urandom));
    end
    exp_ir = exp_ir + 32'd1;
  endfunction

  // Applies the first n stimulus cycles, sampling outputs 1 time unit after
  // each negedge; finishes just after the following rising edge.
  task automatic drive(input int n);
    obs_q.delete();
    for (int i = 0; i < n && i < stim_q.size(); i++) begin
      @(negedge clk);
      opcode    = stim_q[i].op;
      mem_ready = stim_q[i].rdy;
      br_taken  = stim_q[i].bt;
      #1;
      obs_q.push_back(sample());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    exp_ir = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP; mem_ready = 1'b1; br_taken = 1'b1;
    exp_ir = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sample() !== vec_t'(0)) begin
      fails++; $display("FAIL reset_outputs: got %h expected %h", sample(), vec_t'(0));
    end
    checks++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    checks++;
    if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret: got %h expected 0", instret); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0) begin fails++; $display("FAIL reset_idle: got %0d expected 0", state); end
  endtask

  task automatic test_op_basic();
    build(OP, 1'b0, 0, 0);
    drive(stim_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL op_basic cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (instret !== exp_ir) begin fails++; $display("FAIL op_basic_instret: got %h expected %h", instret, exp_ir); end
    checks++;
    if (state !== 3'd1) begin fails++; $display("FAIL op_basic_refetch: got %0d expected 1", state); end
  endtask

  task automatic test_load_wait();
    build(LOAD, 1'b0, 0, 3);
    drive(stim_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL load_wait cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (instret !== exp_ir) begin fails++; $display("FAIL load_wait_instret: got %h expected %h", instret, exp_ir); end
  endtask

  task automatic test_store_branch();
    logic [6:0] ops [3];
    logic       bts [3];
    ops[0] = STORE;  bts[0] = 1'b0;
    ops[1] = BRANCH; bts[1] = 1'b1;
    ops[2] = BRANCH; bts[2] = 1'b0;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      build(ops[k], bts[k], 0, 0);
      drive(stim_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL store_branch instr %0d cycle %0d: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (instret !== exp_ir) begin fails++; $display("FAIL store_branch_instret: got %h expected %h", instret, exp_ir); end
  endtask

  task automatic test_jal_jalr();
    logic [6:0] ops [2];
    ops[0] = JAL;
    ops[1] = JALR;
    for (int k = 0; k < 2; k++) begin
      build(ops[k], 1'($urandom), k, 0);
      drive(stim_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL jal_jalr instr %0d cycle %0d: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (instret !== exp_ir) begin fails++; $display("FAIL jal_jalr_instret: got %h expected %h", instret, exp_ir); end
  endtask

  task automatic test_illegal();
    vec_t v;
    apply_reset();
    exp_q.delete();
    stim_q.delete();
    v = '0; v.st = 3'd1; v.mem_req = 1'b1; v.ir_we = 1'b1;
    add(v, 7'($urandom), 1'b1, 1'b0);
    v = '0; v.st = 3'd2;
    add(v, 7'b1111111, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 20; i++) begin
      v = '0; v.st = 3'd6;
      add(v, 7'b1111111, 1'($urandom), 1'($urandom));
    end
    drive(stim_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_flag: got %b expected 1", illegal); end
    checks++;
    if (instret !== exp_ir) begin fails++; $display("FAIL illegal_instret: got %h expected %h", instret, exp_ir); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL illegal_clear: got %b expected 0", illegal); end
    checks++;
    if (state !== 3'd0) begin fails++; $display("FAIL illegal_reset_state: got %0d expected 0", state); end
    @(negedge clk);
    rst_n  = 1'b1;
    exp_ir = '0;
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    build(BRANCH, 1'b1, 0, 0);
    drive(stim_q.size());
    checks++;
    if (instret !== exp_ir) begin fails++; $display("FAIL midmem_pre_instret: got %h expected %h", instret, exp_ir); end
    build(LOAD, 1'b0, 0, 5);
    drive(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL midmem cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (sample() !== vec_t'(0)) begin
      fails++; $display("FAIL midmem_reset_outputs: got %h expected %h", sample(), vec_t'(0));
    end
    checks++;
    if (instret !== 32'd0) begin fails++; $display("FAIL midmem_reset_instret: got %h expected 0", instret); end
    @(negedge clk);
    rst_n  = 1'b1;
    exp_ir = '0;
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    exp_ir = 32'hFFFF_FFFF;
    checks++;
    if (instret !== exp_ir) begin fails++; $display("FAIL wrap_preset: got %h expected %h", instret, exp_ir); end
    build(BRANCH, 1'($urandom), 0, 0);
    drive(stim_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL wrap cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (instret !== 32'd0) begin fails++; $display("FAIL wrap_instret: got %h expected 0", instret); end
    build(OPIMM, 1'b0, 0, 0);
    drive(stim_q.size());
    checks++;
    if (instret !== 32'd1) begin fails++; $display("FAIL wrap_next_instret: got %h expected 1", instret); end
  endtask

  task automatic test_random();
    logic [6:0] op;
    apply_reset();
    legal_ops[0] = LUI;    legal_ops[1] = AUIPC; legal_ops[2] = JAL;
    legal_ops[3] = JALR;   legal_ops[4] = BRANCH; legal_ops[5] = LOAD;
    legal_ops[6] = STORE;  legal_ops[7] = OPIMM; legal_ops[8] = OP;
    for (int k = 0; k < 150; k++) begin
      op = legal_ops[$urandom_range(8, 0)];
      build(op, 1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      drive(stim_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL random instr %0d op %b cycle %0d: got %h expected %h", k, op, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (instret !== exp_ir) begin
        fails++; $display("FAIL random_instret instr %0d: got %h expected %h", k, instret, exp_ir);
      end
    end
    checks++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL random_illegal: got %b expected 0", illegal); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the test sequence completed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_op_basic();
    test_load_wait();
    test_store_branch();
    test_jal_jalr();
    test_illegal();
    test_reset_mid_mem();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
